// File: rtl/imem_dbg_pkg.sv
// rtl/imem_dbg_pkg.sv - shared states, error codes and constants for the imem debug loader
package imem_dbg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_DRAIN,
    ST_RDADDR,
    ST_RDLAST,
    ST_DONE,
    ST_ERROR
  } state_t;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_RANGE = 2'd1;
  localparam logic [1:0] ERR_CSUM  = 2'd2;

  localparam logic [3:0] WE_ALL = 4'hF;

endpackage

// File: rtl/imem_debug_loader_if.sv
// rtl/imem_debug_loader_if.sv - word stream plus instruction RAM debug port bundle
interface imem_debug_loader_if;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic [31:0] A2;
  logic [31:0] WD2;
  logic [3:0]  WE2;
  logic [31:0] RD2;

  modport master (
    input  in_valid, in_data, RD2,
    output in_ready, A2, WD2, WE2
  );

  modport slave (
    output in_valid, in_data, RD2,
    input  in_ready, A2, WD2, WE2
  );
endinterface

// File: rtl/imem_csum_acc.sv
// rtl/imem_csum_acc.sv - 32-bit clear/accumulate register for the additive checksum
module imem_csum_acc (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        add_en,
  input  logic [31:0] add_val,
  output logic [31:0] sum
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
    end else if (clr) begin
      sum <= '0;
    end else if (add_en) begin
      sum <= sum + add_val;
    end
  end

endmodule

// File: rtl/imem_debug_loader.sv
// rtl/imem_debug_loader.sv - streams words into instruction RAM via the debug port, then verifies by checksum
module imem_debug_loader
  import imem_dbg_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [31:0]          base_addr,
  input  logic [CNT_W-1:0]     word_cnt,
  imem_debug_loader_if.master  bus,
  output logic                 cpu_hold,
  output logic                 done,
  output logic                 err,
  output logic [1:0]           err_code
);

  localparam int SUM_W = CNT_W + 30;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state;
  logic [31:0]      base;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] wr_idx;
  logic [CNT_W-1:0] rd_idx;
  logic [31:0]      sum_w;
  logic [31:0]      sum_r;

  logic             idle_like;
  logic             start_ok;
  logic             wr_hs;
  logic             rd_add;
  logic [SUM_W-1:0] end_word;
  logic [31:0]      sum_r_final;

  assign idle_like   = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR);
  assign start_ok    = start && idle_like;
  assign wr_hs       = (state == ST_WRITE) && bus.in_ready && bus.in_valid;
  // RD2 lags A2 by one cycle, so the first read cycle has nothing to add yet
  assign rd_add      = ((state == ST_RDADDR) && (rd_idx != '0)) || (state == ST_RDLAST);
  assign end_word    = SUM_W'(base_addr[31:2]) + SUM_W'(word_cnt);
  assign sum_r_final = sum_r + bus.RD2;

  imem_csum_acc u_sum_w (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (start_ok),
    .add_en  (wr_hs),
    .add_val (bus.in_data),
    .sum     (sum_w)
  );

  imem_csum_acc u_sum_r (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (start_ok),
    .add_en  (rd_add),
    .add_val (bus.RD2),
    .sum     (sum_r)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      base         <= '0;
      cnt          <= '0;
      wr_idx       <= '0;
      rd_idx       <= '0;
      bus.A2       <= '0;
      bus.WD2      <= '0;
      bus.WE2      <= '0;
      bus.in_ready <= 1'b0;
      cpu_hold     <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      err_code     <= ERR_NONE;
    end else begin
      bus.WE2 <= '0;
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
            base     <= base_addr & ~32'h3;
            cnt      <= word_cnt;
            wr_idx   <= '0;
            rd_idx   <= '0;
            if (end_word > SUM_W'(DEPTH_WORDS)) begin
              err      <= 1'b1;
              err_code <= ERR_RANGE;
              state    <= ST_ERROR;
            end else if (word_cnt == '0) begin
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              cpu_hold <= 1'b1;
              state    <= ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          bus.in_ready <= 1'b1;
          if (wr_hs) begin
            bus.A2  <= base + (32'(wr_idx) << 2);
            bus.WD2 <= bus.in_data;
            bus.WE2 <= WE_ALL;
            wr_idx  <= wr_idx + ONE;
            if (wr_idx == cnt - ONE) begin
              bus.in_ready <= 1'b0;
              state        <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          bus.A2 <= base;
          rd_idx <= '0;
          state  <= ST_RDADDR;
        end
        ST_RDADDR: begin
          if (rd_idx == cnt - ONE) begin
            state <= ST_RDLAST;
          end else begin
            bus.A2 <= bus.A2 + 32'd4;
            rd_idx <= rd_idx + ONE;
          end
        end
        ST_RDLAST: begin
          cpu_hold <= 1'b0;
          if (sum_r_final == sum_w) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            err      <= 1'b1;
            err_code <= ERR_CSUM;
            state    <= ST_ERROR;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_debug_loader.sv
// tb/tb_imem_debug_loader.sv - self-checking bench with a 1-cycle-latency instruction RAM model
module tb_imem_debug_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] word_cnt = '0;
  logic        cpu_hold, done, err;
  logic [1:0]  err_code;

  imem_debug_loader_if bus ();

  imem_debug_loader #(.DEPTH_WORDS(4096), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .word_cnt  (word_cnt),
    .bus       (bus.master),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .err       (err),
    .err_code  (err_code)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] ram [0:4095];
  logic        corrupt = 1'b0;
  logic [31:0] img [int];
  logic [31:0] words [0:15];

  logic [63:0] wr_q [$];
  int          we_bad = 0;
  int          hold_cycles = 0;
  logic        hs_d = 1'b0;

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
  end

  // RAM model: write on WE2, registered read, optional single-bit corruption at 0x104
  always @(posedge clk) begin
    if (bus.WE2 == 4'hF) ram[bus.A2[13:2]] <= bus.WD2;
    bus.RD2 <= ram[bus.A2[13:2]] ^ ((corrupt && bus.A2 == 32'h104) ? 32'h1 : 32'h0);
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      hs_d <= 1'b0;
    end else begin
      if ((bus.WE2 == 4'hF) != hs_d) we_bad <= we_bad + 1;
      if (bus.WE2 != 4'h0) wr_q.push_back({bus.A2, bus.WD2});
      if (cpu_hold) hold_cycles <= hold_cycles + 1;
      hs_d <= bus.in_valid && bus.in_ready;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_words(input int kind);
    logic [31:0] fixed [0:3];
    fixed[0] = 32'h00000013; fixed[1] = 32'h00100093;
    fixed[2] = 32'h00200113; fixed[3] = 32'h002081B3;
    for (int w = 0; w < 16; w++) words[w] = (kind == 0 && w < 4) ? fixed[w] : $urandom;
  endtask

  // mode: 0 valid always high, 1 valid toggles 1,0,1,0, 2 random valid
  task automatic run_load(input string name, input logic [31:0] base, input int cnt,
                          input int mode, input logic corr);
    longint bw;
    logic   exp_range, exp_csum;
    int     k, cyc, q0, wb0, h0, bad;
    logic [31:0] esum_w, esum_r, rb;
    bw = longint'(base >> 2);
    exp_range = (bw + cnt) > 4096;
    q0 = wr_q.size(); wb0 = we_bad; h0 = hold_cycles;
    corrupt = corr;
    base_addr = base; word_cnt = 16'(cnt); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (exp_range) begin
      chk({name, " range_err_next_cycle"}, {err, err_code, done}, {1'b1, 2'd1, 1'b0});
      chk({name, " range_no_hold"}, 64'(cpu_hold), 64'(0));
    end else if (cnt == 0) begin
      chk({name, " cnt0_done_next_cycle"}, {done, err, err_code}, {1'b1, 1'b0, 2'd0});
    end else begin
      chk({name, " accept_clears_status"}, {done, err, cpu_hold}, {1'b0, 1'b0, 1'b1});
    end
    k = 0; cyc = 0;
    while (!(done || err) && cyc < 300) begin
      bus.in_valid = (k < cnt) && ((mode == 0) || (mode == 1 && cyc % 2 == 0) ||
                                   (mode == 2 && $urandom_range(0, 1) == 1));
      bus.in_data = bus.in_valid ? words[k] : $urandom;
      if (bus.in_valid && bus.in_ready) k++;
      @(negedge clk);
      cyc++;
    end
    bus.in_valid = 1'b0;
    chk({name, " finished_in_budget"}, 64'(done || err), 64'(1));
    if (exp_range) begin
      chk({name, " range_no_writes"}, 64'(wr_q.size() - q0), 64'(0));
      chk({name, " range_hold_cycles"}, 64'(hold_cycles - h0), 64'(0));
      return;
    end
    for (int j = 0; j < cnt; j++) img[int'(bw) + j] = words[j];
    esum_w = '0; esum_r = '0; bad = 0;
    for (int j = 0; j < cnt; j++) begin
      rb = ram[int'(bw) + j];
      if (rb !== img[int'(bw) + j]) bad++;
      if ((wr_q.size() <= q0 + j) || (wr_q[q0 + j] !== {base + 32'(4 * j), words[j]})) bad++;
      esum_w += words[j];
      esum_r += rb ^ ((corr && (base + 32'(4 * j)) == 32'h104) ? 32'h1 : 32'h0);
    end
    exp_csum = (esum_w != esum_r);
    chk({name, " writes_and_image"}, 64'(bad), 64'(0));
    chk({name, " write_count"}, 64'(wr_q.size() - q0), 64'(cnt));
    chk({name, " we2_only_after_handshake"}, 64'(we_bad - wb0), 64'(0));
    chk({name, " result"}, {done, err, err_code},
        exp_csum ? {1'b0, 1'b1, 2'd2} : {1'b1, 1'b0, 2'd0});
    chk({name, " idle_outputs"}, {cpu_hold, bus.in_ready, bus.WE2}, 64'(0));
    chk({name, " hold_equals_busy"}, 64'(hold_cycles - h0), 64'(cyc));
    if (mode == 0) chk({name, " latency"}, 64'(cyc), (cnt == 0) ? 64'(0) : 64'(2 * cnt + 3));
  endtask

  initial begin
    int q0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {bus.A2, bus.WD2, bus.WE2, bus.in_ready, cpu_hold, done, err, err_code},
        '0);
    rst_n = 1'b1;
    @(negedge clk);

    fill_words(0);
    run_load("t1_back_to_back", 32'h100, 4, 0, 1'b0);
    run_load("t2_toggle_valid", 32'h100, 4, 1, 1'b0);
    run_load("t3_range", 32'h3FFC, 2, 0, 1'b0);
    run_load("t4_csum", 32'h100, 4, 0, 1'b1);
    run_load("t5_cnt0", 32'h200, 0, 0, 1'b0);
    run_load("t5_cnt1", 32'h200, 1, 0, 1'b0);
    run_load("boundary_top_word", 32'h3FF0, 4, 0, 1'b0);

    // reset mid-load after two writes
    q0 = wr_q.size();
    base_addr = 32'h100; word_cnt = 16'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 50 && (wr_q.size() - q0) < 2; c++) begin
      bus.in_data = words[wr_q.size() - q0];
      @(negedge clk);
    end
    chk("t6_two_writes_seen", 64'(wr_q.size() - q0), 64'(2));
    rst_n = 1'b0;
    #1;
    chk("t6_async_reset_outputs",
        {bus.A2, bus.WD2, bus.WE2, bus.in_ready, cpu_hold, done, err, err_code}, '0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_load("t6_after_reset", 32'h100, 4, 0, 1'b0);

    for (int r = 0; r < 4; r++) begin
      fill_words(1);
      run_load("rand_load", 32'($urandom_range(0, 4000)) << 2, $urandom_range(1, 8), 2, 1'b0);
    end
    run_load("rand_range", 32'($urandom_range(4090, 4095)) << 2, 8, 2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
